onchip_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single-port 8192 x 32 on-chip RAM between the ADC sample writer (port 0) and the Nios data master (port 1). It sits between the two masters and the RAM's s1 slave port. It grants at most one transfer per cycle using round-robin with a bounded burst hold, and it returns read data with a fixed one-cycle latency tagged to the requester that issued the read.

---
 rtl/onchip_mem_arbiter_if.sv | 50 +++++
 rtl/onchip_mem_arbiter.sv | 116 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the RAM s1 port.
// The slave modport is the arbiter's view; the master modport is the masters'/RAM-model view.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   m0_address;
   logic [DATA_W/8-1:0] m0_byteenable;
   logic                m0_read;
   logic                m0_write;
   logic [DATA_W-1:0]   m0_writedata;
   logic                m0_waitrequest;
   logic [DATA_W-1:0]   m0_readdata;
   logic                m0_readdatavalid;

   logic [ADDR_W-1:0]   m1_address;
   logic [DATA_W/8-1:0] m1_byteenable;
   logic                m1_read;
   logic                m1_write;
   logic [DATA_W-1:0]   m1_writedata;
   logic                m1_waitrequest;
   logic [DATA_W-1:0]   m1_readdata;
   logic                m1_readdatavalid;

   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W-1:0]   mem_writedata;
   logic                mem_clken;
   logic [DATA_W-1:0]   mem_readdata;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter with bounded burst hold in front of a single-port RAM.
// Read data returns one cycle after acceptance, tagged to the issuing port.
module onchip_mem_arbiter #(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   onchip_mem_arbiter_if.slave  bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [1:0]        rd_pend_q, rd_pend_d;
   logic [1:0]        req_s;
   logic [1:0]        grant_s;
   logic              req_own_s, req_oth_s;
   logic [ADDR_W-1:0] mem_address_s;
   logic [BE_W-1:0]   mem_byteenable_s;
   logic [DATA_W-1:0] mem_writedata_s;
   logic              mem_write_s;

   assign req_s     = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
   assign req_own_s = owner_q ? req_s[1] : req_s[0];
   assign req_oth_s = owner_q ? req_s[0] : req_s[1];

   // Arbitration. A zero burst count means no burst is in progress (reset or an
   // idle cycle), so under contention the non-owner takes the next turn.
   always_comb begin
      grant_s     = 2'b00;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      if (!reset_n) begin
         grant_s = 2'b00;
      end else if (req_own_s && (!req_oth_s ||
                   ((burst_cnt_q != ZERO_CNT) && (burst_cnt_q < MAX_CNT)))) begin
         grant_s = owner_q ? 2'b10 : 2'b01;
         if (burst_cnt_q != MAX_CNT) begin
            burst_cnt_d = burst_cnt_q + ONE_CNT;
         end else begin
            burst_cnt_d = burst_cnt_q;
         end
      end else if (req_oth_s) begin
         grant_s     = owner_q ? 2'b01 : 2'b10;
         owner_d     = ~owner_q;
         burst_cnt_d = ONE_CNT;
      end else begin
         burst_cnt_d = ZERO_CNT;
      end
   end

   // Memory-side mux from the granted port; all zero when nothing is granted.
   always_comb begin
      mem_address_s    = {ADDR_W{1'b0}};
      mem_byteenable_s = {BE_W{1'b0}};
      mem_writedata_s  = {DATA_W{1'b0}};
      mem_write_s      = 1'b0;
      case (grant_s)
         2'b01: begin
            mem_address_s    = bus.m0_address;
            mem_byteenable_s = bus.m0_byteenable;
            mem_writedata_s  = bus.m0_writedata;
            mem_write_s      = bus.m0_write;
         end
         2'b10: begin
            mem_address_s    = bus.m1_address;
            mem_byteenable_s = bus.m1_byteenable;
            mem_writedata_s  = bus.m1_writedata;
            mem_write_s      = bus.m1_write;
         end
         default: begin
            mem_address_s    = {ADDR_W{1'b0}};
            mem_byteenable_s = {BE_W{1'b0}};
            mem_writedata_s  = {DATA_W{1'b0}};
            mem_write_s      = 1'b0;
         end
      endcase
   end

   // A read-with-write is treated as a write and earns no read response.
   assign rd_pend_d = {grant_s[1] & bus.m1_read & ~bus.m1_write,
                       grant_s[0] & bus.m0_read & ~bus.m0_write};

   // Arbiter state and read-return tags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         owner_q     <= 1'b1;
         burst_cnt_q <= ZERO_CNT;
         rd_pend_q   <= 2'b00;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   assign bus.m0_waitrequest   = ~grant_s[0];
   assign bus.m1_waitrequest   = ~grant_s[1];
   assign bus.m0_readdatavalid = rd_pend_q[0] & reset_n;
   assign bus.m1_readdatavalid = rd_pend_q[1] & reset_n;
   assign bus.m0_readdata      = bus.mem_readdata;
   assign bus.m1_readdata      = bus.mem_readdata;

   assign bus.mem_address    = mem_address_s;
   assign bus.mem_byteenable = mem_byteenable_s;
   assign bus.mem_writedata  = mem_writedata_s;
   assign bus.mem_chipselect = grant_s[0] | grant_s[1];
   assign bus.mem_write      = mem_write_s;
   assign bus.mem_clken      = 1'b1;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench: unit A uses MAX_BURST=4, unit B uses MAX_BURST=1; each has its own RAM model.
module tb_onchip_mem_arbiter;
   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;
   int   checks = 0;
   int   errors = 0;

   logic [1:0]  exp_acc_a[$];
   logic [1:0]  exp_acc_b[$];
   logic [32:0] exp_rd_a[$];
   logic [32:0] exp_rd_b[$];
   logic [31:0] ram_a [0:8191];
   logic [31:0] ram_b [0:8191];

   always #5 clk = ~clk;

   onchip_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus_a();
   onchip_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus_b();

   onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_BURST(4)) dut_a (
      .clk(clk), .reset_n(reset_a), .bus(bus_a));
   onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_BURST(1)) dut_b (
      .clk(clk), .reset_n(reset_b), .bus(bus_b));

   // RAM models: registered read, byte-lane writes
   always @(posedge clk) begin
      if (bus_a.mem_chipselect) begin
         if (bus_a.mem_write)
            for (int b = 0; b < 4; b++)
               if (bus_a.mem_byteenable[b]) ram_a[bus_a.mem_address][8*b +: 8] <= bus_a.mem_writedata[8*b +: 8];
         bus_a.mem_readdata <= ram_a[bus_a.mem_address];
      end
   end
   always @(posedge clk) begin
      if (bus_b.mem_chipselect) begin
         if (bus_b.mem_write)
            for (int b = 0; b < 4; b++)
               if (bus_b.mem_byteenable[b]) ram_b[bus_b.mem_address][8*b +: 8] <= bus_b.mem_writedata[8*b +: 8];
         bus_b.mem_readdata <= ram_b[bus_b.mem_address];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int u, input logic acc0, input logic acc1, input logic mw,
                      input logic rdv0, input logic rdv1, input logic [31:0] rdata);
      logic [1:0]  ea;
      logic [32:0] er;
      logic        empty;
      if (acc0 || acc1) begin
         chk($sformatf("u%0d_single_grant", u), 32'(acc0 & acc1), 32'd0);
         empty = (u == 0) ? (exp_acc_a.size() == 0) : (exp_acc_b.size() == 0);
         if (empty) begin
            checks++; errors++;
            $display("FAIL u%0d_unexpected_accept actual=port%0d expected=none at %0t", u, acc1, $time);
         end else begin
            ea = (u == 0) ? exp_acc_a.pop_front() : exp_acc_b.pop_front();
            chk($sformatf("u%0d_accept_port", u), 32'(acc1), 32'(ea[0]));
            chk($sformatf("u%0d_accept_memwrite", u), 32'(mw), 32'(ea[1]));
         end
      end
      if (rdv0 || rdv1) begin
         chk($sformatf("u%0d_single_rdv", u), 32'(rdv0 & rdv1), 32'd0);
         empty = (u == 0) ? (exp_rd_a.size() == 0) : (exp_rd_b.size() == 0);
         if (empty) begin
            checks++; errors++;
            $display("FAIL u%0d_unexpected_rdv actual=port%0d expected=none at %0t", u, rdv1, $time);
         end else begin
            er = (u == 0) ? exp_rd_a.pop_front() : exp_rd_b.pop_front();
            chk($sformatf("u%0d_rdv_port", u), 32'(rdv1), 32'(er[32]));
            chk($sformatf("u%0d_rdata", u), rdata, er[31:0]);
         end
      end
   endtask

   // Monitor: sample away from the active edge and score every accept and read return
   always @(negedge clk) begin
      mon(0, (bus_a.m0_read | bus_a.m0_write) & ~bus_a.m0_waitrequest,
             (bus_a.m1_read | bus_a.m1_write) & ~bus_a.m1_waitrequest,
             bus_a.mem_write, bus_a.m0_readdatavalid, bus_a.m1_readdatavalid,
             bus_a.m1_readdatavalid ? bus_a.m1_readdata : bus_a.m0_readdata);
      mon(1, (bus_b.m0_read | bus_b.m0_write) & ~bus_b.m0_waitrequest,
             (bus_b.m1_read | bus_b.m1_write) & ~bus_b.m1_waitrequest,
             bus_b.mem_write, bus_b.m0_readdatavalid, bus_b.m1_readdatavalid,
             bus_b.m1_readdatavalid ? bus_b.m1_readdata : bus_b.m0_readdata);
   end

   task automatic set(input int u, input int p, input logic rd, input logic wr,
                      input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
      if (u == 0 && p == 0) begin
         bus_a.m0_read = rd; bus_a.m0_write = wr; bus_a.m0_address = a; bus_a.m0_writedata = d; bus_a.m0_byteenable = be;
      end else if (u == 0) begin
         bus_a.m1_read = rd; bus_a.m1_write = wr; bus_a.m1_address = a; bus_a.m1_writedata = d; bus_a.m1_byteenable = be;
      end else if (p == 0) begin
         bus_b.m0_read = rd; bus_b.m0_write = wr; bus_b.m0_address = a; bus_b.m0_writedata = d; bus_b.m0_byteenable = be;
      end else begin
         bus_b.m1_read = rd; bus_b.m1_write = wr; bus_b.m1_address = a; bus_b.m1_writedata = d; bus_b.m1_byteenable = be;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 8192; i++) begin
         ram_a[i] = 32'h0;
         ram_b[i] = 32'h0;
      end
      reset_a = 1'b0;
      reset_b = 1'b0;
      for (int u = 0; u < 2; u++)
         for (int p = 0; p < 2; p++) set(u, p, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);

      // Reset held 3 cycles with a pending m0 write
      set(0, 0, 1'b0, 1'b1, 13'h0010, 32'hDEADBEEF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_wait0", 32'(bus_a.m0_waitrequest), 32'd1);
         chk("rst_wait1", 32'(bus_a.m1_waitrequest), 32'd1);
         chk("rst_cs", 32'(bus_a.mem_chipselect), 32'd0);
         chk("rst_rdv", 32'({bus_a.m1_readdatavalid, bus_a.m0_readdatavalid}), 32'd0);
         cyc();
      end
      reset_a = 1'b1;
      exp_acc_a.push_back(2'b10);
      cyc();

      // Single read by m1
      set(0, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(0, 1, 1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
      exp_acc_a.push_back(2'b01);
      exp_rd_a.push_back({1'b1, 32'hDEADBEEF});
      cyc();

      // Byte-lane write then read back
      set(0, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(0, 0, 1'b0, 1'b1, 13'h0010, 32'h11223344, 4'h3);
      exp_acc_a.push_back(2'b10);
      cyc();
      set(0, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(0, 1, 1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
      exp_acc_a.push_back(2'b01);
      exp_rd_a.push_back({1'b1, 32'hDEAD3344});
      cyc();
      set(0, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("idle_wait0", 32'(bus_a.m0_waitrequest), 32'd1);
      chk("idle_wait1", 32'(bus_a.m1_waitrequest), 32'd1);
      chk("idle_memaddr", 32'(bus_a.mem_address), 32'd0);
      cyc();

      // Preload distinct words for the contention run
      set(0, 0, 1'b0, 1'b1, 13'h0020, 32'hA0A0A0A0, 4'hF);
      exp_acc_a.push_back(2'b10);
      cyc();
      set(0, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(0, 1, 1'b0, 1'b1, 13'h0030, 32'hB1B1B1B1, 4'hF);
      exp_acc_a.push_back(2'b11);
      cyc();
      set(0, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      cyc();

      // Contention from reset release, MAX_BURST = 4
      reset_a = 1'b0;
      set(0, 0, 1'b1, 1'b0, 13'h0020, 32'h0, 4'h0);
      set(0, 1, 1'b1, 1'b0, 13'h0030, 32'h0, 4'h0);
      @(negedge clk);
      chk("rst2_wait0", 32'(bus_a.m0_waitrequest), 32'd1);
      chk("rst2_wait1", 32'(bus_a.m1_waitrequest), 32'd1);
      cyc();
      for (int k = 0; k < 10; k++) begin
         reset_a = 1'b1;
         exp_acc_a.push_back({1'b0, seq[k][0]});
         exp_rd_a.push_back({seq[k][0], (seq[k] == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0});
         cyc();
      end
      set(0, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(0, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      cyc();

      // Reset arriving the cycle after a read is accepted
      set(0, 0, 1'b1, 1'b0, 13'h0020, 32'h0, 4'h0);
      exp_acc_a.push_back(2'b00);
      cyc();
      set(0, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      reset_a = 1'b0;
      @(negedge clk);
      chk("midrst_rdv_t1", 32'(bus_a.m0_readdatavalid), 32'd0);
      cyc();
      reset_a = 1'b1;
      set(0, 1, 1'b1, 1'b0, 13'h0030, 32'h0, 4'h0);
      exp_acc_a.push_back(2'b01);
      exp_rd_a.push_back({1'b1, 32'hB1B1B1B1});
      @(negedge clk);
      chk("midrst_rdv_t2", 32'(bus_a.m0_readdatavalid), 32'd0);
      chk("midrst_m1_grant", 32'(bus_a.m1_waitrequest), 32'd0);
      cyc();
      set(0, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      cyc();

      // Unit B, MAX_BURST = 1: continuous writes alternate strictly
      for (int k = 0; k < 6; k++) begin
         reset_b = 1'b1;
         set(1, 0, 1'b0, 1'b1, 13'h0040, 32'h0A000000 + 32'(k), 4'hF);
         set(1, 1, 1'b0, 1'b1, 13'h0041, 32'h0B000000 + 32'(k), 4'hF);
         exp_acc_b.push_back({1'b1, k[0]});
         cyc();
      end
      set(1, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(1, 1, 1'b1, 1'b0, 13'h0040, 32'h0, 4'h0);
      exp_acc_b.push_back(2'b01);
      exp_rd_b.push_back({1'b1, 32'h0A000004});
      cyc();
      set(1, 1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      set(1, 0, 1'b1, 1'b0, 13'h0041, 32'h0, 4'h0);
      exp_acc_b.push_back(2'b00);
      exp_rd_b.push_back({1'b0, 32'h0B000005});
      cyc();
      set(1, 0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      cyc();
      cyc();

      chk("left_acc_a", 32'(exp_acc_a.size()), 32'd0);
      chk("left_rd_a", 32'(exp_rd_a.size()), 32'd0);
      chk("left_acc_b", 32'(exp_acc_b.size()), 32'd0);
      chk("left_rd_b", 32'(exp_rd_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
